// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches four bytes per opcode over the byte-wide
// MMU port, assembles them big-endian and queues opcode/PC pairs for decode.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_request,
  input  logic [7:0]            mem_data,
  input  logic                  mem_busy,
  output logic                  out_valid,
  output logic [31:0]           out_opcode,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           partial_q, partial_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  drop_q, drop_d;
  logic                  first_q, first_d;
  logic [31:0]           opc_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q  [DEPTH];
  logic                  push, pop;
  logic [CW-1:0]         count_after_pop;

  assign out_valid  = (count_q != '0);
  assign out_opcode = opc_q[head_q];
  assign out_pc     = pc_q[head_q];

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    addr_d          = addr_q;
    byte_idx_d      = byte_idx_q;
    partial_d       = partial_q;
    head_d          = head_q;
    tail_d          = tail_q;
    drop_d          = drop_q;
    first_d         = first_q;
    push            = 1'b0;
    mem_request     = 1'b0;
    mem_addr        = addr_q;
    pop             = out_valid && out_ready;
    count_after_pop = count_q - CW'(pop);

    case (state_q)
      S_IDLE: begin
        if (!redirect && (count_after_pop < CW'(DEPTH))) begin
          state_d    = S_ISSUE;
          byte_idx_d = '0;
        end
      end
      S_ISSUE: begin
        // A redirect here cannot cancel the strobe; the byte is dropped in WAIT.
        mem_request = 1'b1;
        mem_addr    = fetch_pc_q + ADDR_WIDTH'(byte_idx_q);
        addr_d      = mem_addr;
        first_d     = 1'b1;
        state_d     = S_WAIT;
        if (redirect) drop_d = 1'b1;
      end
      S_WAIT: begin
        first_d = 1'b0;
        if (!first_q && !mem_busy) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else if (byte_idx_q != 2'd3) begin
            partial_d  = {partial_q[15:0], mem_data};
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_ISSUE;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            byte_idx_d = '0;
            partial_d  = '0;
            state_d    = S_IDLE;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Redirect overrides queue bookkeeping; FSM progress above is kept.
    if (redirect) begin
      push       = 1'b0;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc & ~ADDR_WIDTH'(3);
      byte_idx_d = '0;
      partial_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      addr_q     <= '0;
      byte_idx_q <= '0;
      partial_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      byte_idx_q <= byte_idx_d;
      partial_q  <= partial_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      first_q    <= first_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opc_q <= '{default: '0};
      pc_q  <= '{default: '0};
    end else if (push) begin
      opc_q[tail_q] <= {partial_q, mem_data};
      pc_q[tail_q]  <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue with a behavioural MMU port B.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] mem_addr;
  logic        mem_request;
  logic [7:0]  mem_data = '0;
  logic        mem_busy = 1'b0;
  logic        out_valid;
  logic [31:0] out_opcode;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // MMU model state
  int          req_count = 0;
  int          stretch_byte = 4;
  int          stretch_len = 1;
  int          mmu_rem = 0;
  logic        mmu_active = 1'b0;
  logic [31:0] mmu_addr = '0;

  typedef struct {
    logic [31:0] op;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        do_redir;
    logic [31:0] rpc;
    int          sbyte;
    int          slen;
    int          exp_lat;
    logic [31:0] exp_op;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[5];

  instr_prefetch_queue #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_request(mem_request), .mem_data(mem_data),
    .mem_busy(mem_busy), .out_valid(out_valid), .out_opcode(out_opcode),
    .out_pc(out_pc), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0: mem_byte = 8'h20;
      32'd1: mem_byte = 8'h08;
      32'd2: mem_byte = 8'h00;
      32'd3: mem_byte = 8'h05;
      32'd4: mem_byte = 8'h34;
      32'd5: mem_byte = 8'h09;
      32'd6: mem_byte = 8'h00;
      32'd7: mem_byte = 8'hFF;
      default: mem_byte = a[7:0] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    word_at = {mem_byte(pc), mem_byte(pc + 32'd1), mem_byte(pc + 32'd2), mem_byte(pc + 32'd3)};
  endfunction

  // MMU: busy from the cycle after the request for N cycles, data valid when busy drops.
  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      mmu_active = 1'b0;
      mem_busy   = 1'b0;
      mmu_rem    = 0;
      req_count  = 0;
    end else if (mem_request) begin
      mmu_active = 1'b1;
      mmu_addr   = mem_addr;
      mmu_rem    = ((req_count % 4) == stretch_byte) ? stretch_len : 1;
      req_count  = req_count + 1;
    end else if (mmu_active) begin
      if (mmu_rem > 0) begin
        mem_busy = 1'b1;
        mmu_rem  = mmu_rem - 1;
      end else begin
        mem_busy   = 1'b0;
        mem_data   = mem_byte(mmu_addr);
        mmu_active = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.op = word_at(pc);
    e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    logic found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    check({tag, "_valid_timeout"}, {31'd0, found}, 32'd1);
    if (!found) return;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_entry"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_opcode"}, out_opcode, e.op);
    check({tag, "_pc"}, out_pc, e.pc);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic wait_req(input int n, input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (req_count == n && !mem_request) found = 1'b1;
    end
    check({tag, "_req_timeout"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, 4, 1, 13, 32'h2008_0005, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0000, 1, 5, 17, 32'h2008_0005, 32'h0000_0000};
    vecs[2] = '{1'b1, 32'h0000_0103, 4, 1, 14, 32'h3C3D_3E3F, 32'h0000_0100};
    vecs[3] = '{1'b1, 32'hFFFF_FFFE, 4, 1, 14, 32'hC0C1_C2C3, 32'hFFFF_FFFC};
    vecs[4] = '{1'b1, 32'h0000_0007, 2, 3, 16, 32'h3409_00FF, 32'h0000_0004};

    // Table: first-opcode latency/value/PC after reset, with optional redirect and stretched byte.
    for (int i = 0; i < 5; i++) begin
      logic found;
      stretch_byte = vecs[i].sbyte;
      stretch_len  = vecs[i].slen;
      do_reset();
      redirect    = vecs[i].do_redir;
      redirect_pc = vecs[i].rpc;
      @(negedge clk);
      check($sformatf("v%0d_reset_valid", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("v%0d_reset_req", i), {31'd0, mem_request}, 32'd0);
      if (i == 0) begin
        check("reset_opcode", out_opcode, 32'd0);
        check("reset_pc", out_pc, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
      end
      @(posedge clk);
      #1 redirect = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
        @(negedge clk);
        if (out_valid) found = 1'b1;
      end
      check($sformatf("v%0d_latency", i), cyc, vecs[i].exp_lat);
      check($sformatf("v%0d_opcode", i), out_opcode, vecs[i].exp_op);
      check($sformatf("v%0d_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("v%0d_req_pulses", i), req_count, 32'd4);
    end
    stretch_byte = 4;
    stretch_len  = 1;

    // Fill with no consumer, then free one slot.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) push_exp(32'(i * 4));
    repeat (90) @(posedge clk);
    @(negedge clk);
    check("fill_req_count", req_count, 32'd16);
    check("fill_valid", {31'd0, out_valid}, 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("fill_no_more_req", req_count, 32'd16);
    pop_check("fill_pop0");
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("refill_req_count", req_count, 32'd20);
    for (int i = 0; i < 4; i++) pop_check($sformatf("fill_pop%0d", i + 1));

    // Redirect while byte 2 of the second word is in flight.
    do_reset();
    wait_req(7, "redir_wait");
    check("redir_pre_valid", {31'd0, out_valid}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    begin
      logic found;
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
        @(negedge clk);
        if (mem_request) found = 1'b1;
      end
      check("redir_req_seen", {31'd0, found}, 32'd1);
      check("redir_new_addr", mem_addr, 32'h0000_0100);
    end
    exp_q.delete();
    push_exp(32'h0000_0100);
    push_exp(32'h0000_0104);
    pop_check("redir_pop0");
    pop_check("redir_pop1");

    // Redirect and pop in the same cycle with two entries queued.
    do_reset();
    wait_req(9, "rpop_wait");
    check("rpop_pre_valid", {31'd0, out_valid}, 32'd1);
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0000;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    redirect  = 1'b0;
    @(negedge clk);
    check("rpop_flush_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    push_exp(32'h0000_0000);
    push_exp(32'h0000_0004);
    pop_check("rpop_pop0");
    pop_check("rpop_pop1");
    @(negedge clk);
    check("rpop_empty_after_drain", {31'd0, out_valid}, 32'd0);

    // PC wrap at the top of the address space.
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk);
    #1 redirect = 1'b0;
    exp_q.delete();
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    push_exp(32'h0000_0004);
    pop_check("wrap_pop0");
    pop_check("wrap_pop1");
    pop_check("wrap_pop2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
